// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode map and status flag layout.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_PASS = 3'b100,
        OP_NOT  = 3'b101,
        OP_OR   = 3'b110,
        OP_AND  = 3'b111
    } alu_op_e;

    // Packed so that {n, z, c, v} maps directly onto the 4-bit flags bus.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    // Increment/decrement reuse the add/subtract datapath with a constant 1.
    function automatic logic uses_const_one(input alu_op_e op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: maps (a, b, op) to a WIDTH-bit result and status flags.
// Arithmetic is done one bit wider so the top bit gives carry/borrow directly.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    logic [WIDTH-1:0] operand_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             ovf_s;

    // Second operand selection and the shared add/subtract datapath.
    always_comb begin
        if (uses_const_one(op_i)) begin
            operand_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            operand_s = b_i;
        end
        sum_s  = {1'b0, a_i} + {1'b0, operand_s};
        diff_s = {1'b0, a_i} - {1'b0, operand_s};
        // Signed overflow: operands agree in sign (add) or differ (sub) and
        // the result sign departs from operand A.
        add_ovf_s = (a_i[WIDTH-1] == operand_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
        sub_ovf_s = (a_i[WIDTH-1] != operand_s[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
    end

    // Opcode decode into result, carry/borrow and overflow.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op_i)
            OP_ADD, OP_INC: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = add_ovf_s;
            end
            OP_SUB, OP_DEC: begin
                // Bit WIDTH of the wide difference is set exactly when a < operand.
                res_s   = diff_s[WIDTH-1:0];
                carry_s = diff_s[WIDTH];
                ovf_s   = sub_ovf_s;
            end
            OP_PASS: res_s = a_i;
            OP_NOT:  res_s = ~a_i;
            OP_OR:   res_s = a_i | b_i;
            OP_AND:  res_s = a_i & b_i;
            default: begin
                res_s   = {WIDTH{1'b0}};
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    // Assemble the output result and flag bundle.
    always_comb begin
        result_o   = res_s;
        flags_o.n  = res_s[WIDTH-1];
        flags_o.z  = (res_s == {WIDTH{1'b0}});
        flags_o.c  = carry_s;
        flags_o.v  = ovf_s;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready request handshake and a result
// handshake that honours downstream backpressure. S1 holds the captured
// request, S2 holds the computed result and flags, which drive the outputs.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             ack,
    input  logic             ack_ready
);

    // Stage 1: captured request
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    alu_op_e          s1_op_q, s1_op_d;

    // Stage 2: computed result, cleared whenever empty so outputs read 0
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    alu_flags_t       s2_flags_q, s2_flags_d;

    // Handshake terms
    logic             s2_load_possible_s;
    logic             ready_s;
    logic             accept_s;
    logic             s2_load_s;
    logic             retire_s;

    // ALU output for the S1 entry
    logic [WIDTH-1:0] core_result_s;
    alu_flags_t       core_flags_s;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .op_i     (s1_op_q),
        .result_o (core_result_s),
        .flags_o  (core_flags_s)
    );

    // Handshake decode: S2 can take a new entry if empty or retiring now.
    always_comb begin
        s2_load_possible_s = !s2_valid_q || ack_ready;
        ready_s            = !s1_valid_q || s2_load_possible_s;
        accept_s           = enable && ready_s;
        s2_load_s          = s1_valid_q && s2_load_possible_s;
        retire_s           = s2_valid_q && ack_ready;
    end

    // Stage 1 next state: load on accept, otherwise empty out when advancing.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = A;
            s1_b_d     = B;
            s1_op_d    = alu_op_e'(opcode);
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: load from the core, clear on retire, else hold.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (s2_load_s) begin
            s2_valid_d  = 1'b1;
            s2_result_d = core_result_s;
            s2_flags_d  = core_flags_s;
        end else if (retire_s) begin
            s2_valid_d  = 1'b0;
            s2_result_d = {WIDTH{1'b0}};
            s2_flags_d  = 4'b0000;
        end else begin
            s2_valid_d  = s2_valid_q;
        end
    end

    // Pipeline registers with asynchronous reset discarding both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_op_q     <= OP_ADD;
            s2_valid_q  <= 1'b0;
            s2_result_q <= {WIDTH{1'b0}};
            s2_flags_q  <= 4'b0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

    assign ready  = ready_s;
    assign ack    = s2_valid_q;
    assign result = s2_result_q;
    assign flags  = s2_flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a random stream,
// checked against an arithmetic reference model and an in-order queue.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 32-bit instance
    logic        enable = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [2:0]  opcode = 3'd0;
    logic        ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        ack;
    logic        ack_ready = 1'b1;

    // 8-bit instance
    logic        en8 = 1'b0;
    logic [7:0]  a8 = 8'd0;
    logic [7:0]  b8 = 8'd0;
    logic [2:0]  op8 = 3'd0;
    logic        ready8;
    logic [7:0]  result8;
    logic [3:0]  flags8;
    logic        ack8;
    logic        ar8 = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          acc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .A(A), .B(B), .opcode(opcode),
        .ready(ready), .result(result), .flags(flags), .ack(ack), .ack_ready(ack_ready)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable(en8), .A(a8), .B(b8), .opcode(op8),
        .ready(ready8), .result(result8), .flags(flags8), .ack(ack8), .ack_ready(ar8)
    );

    // Reference: plain signed/unsigned integer arithmetic at width w.
    // Returns {n, z, c, v, result[31:0]}.
    function automatic logic [35:0] ref_calc(input int w, input logic [2:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        longint modv, half, ua, ub, sa, sb, r, sr;
        logic c, v, n, z;
        modv = 64'sd1 <<< w;
        half = modv / 64'sd2;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (op == 3'd2 || op == 3'd3) ub = 64'sd1;
        sa = (ua >= half) ? ua - modv : ua;
        sb = (ub >= half) ? ub - modv : ub;
        c = 1'b0;
        v = 1'b0;
        sr = 64'sd0;
        case (op)
            3'd0, 3'd2: begin r = ua + ub; c = (r >= modv); sr = sa + sb; v = (sr >= half) || (sr < -half); end
            3'd1, 3'd3: begin r = ua - ub; c = (ua < ub);   sr = sa - sb; v = (sr >= half) || (sr < -half); end
            3'd4:    r = ua;
            3'd5:    r = ~ua;
            3'd6:    r = ua | ub;
            default: r = ua & ub;
        endcase
        r = r & (modv - 64'sd1);
        n = ((r / half) % 64'sd2) == 64'sd1;
        z = (r == 64'sd0);
        return {n, z, c, v, r[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the 32-bit instance: drive, check against model, advance.
    task automatic cycle(input logic en, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ar);
        logic ack_e, rdy_e, acc, ret;
        logic [35:0] r;
        exp_t e;
        enable = en; opcode = op; A = a; B = b; ack_ready = ar;
        #1;
        ack_e = (q.size() > 0) && (cyc >= q[0].acc + 2);
        rdy_e = (q.size() < 2) || ar;
        chk("ready", {63'd0, ready}, {63'd0, rdy_e});
        chk("ack", {63'd0, ack}, {63'd0, ack_e});
        if (ack_e) begin
            chk("result", {32'd0, result}, {32'd0, q[0].res});
            chk("flags", {60'd0, flags}, {60'd0, q[0].fl});
        end else begin
            chk("result_idle", {32'd0, result}, 64'd0);
            chk("flags_idle", {60'd0, flags}, 64'd0);
        end
        acc = en && rdy_e;
        ret = ack_e && ar;
        r = ref_calc(32, op, a, b);
        @(posedge clk);
        #1;
        if (ret) void'(q.pop_front());
        if (acc) begin
            e.res = r[31:0];
            e.fl  = r[35:32];
            e.acc = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    // Single request on the 8-bit instance with expected constants.
    task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_r, input logic [3:0] exp_f);
        en8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        en8 = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ack"}, {63'd0, ack8}, 64'd1);
        chk({tag, "_result"}, {56'd0, result8}, {56'd0, exp_r});
        chk({tag, "_flags"}, {60'd0, flags8}, {60'd0, exp_f});
        @(posedge clk); #1;
        chk({tag, "_retired"}, {63'd0, ack8}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ack", {63'd0, ack}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_flags", {60'd0, flags}, 64'd0);
        chk("rst_ready", {63'd0, ready}, 64'd1);

        // Back-to-back stream
        cycle(1'b1, OP_ADD, 32'd5, 32'd7, 1'b1);
        cycle(1'b1, OP_SUB, 32'd3, 32'd5, 1'b1);
        chk("b2b_add_r", {32'd0, result}, 64'd12);
        chk("b2b_add_f", {60'd0, flags}, 64'h0);
        cycle(1'b1, OP_INC, 32'hFFFF_FFFF, 32'd0, 1'b1);
        chk("b2b_sub_r", {32'd0, result}, 64'hFFFF_FFFE);
        chk("b2b_sub_f", {60'd0, flags}, 64'hA);
        cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
        chk("b2b_inc_r", {32'd0, result}, 64'd0);
        chk("b2b_inc_f", {60'd0, flags}, 64'h6);
        cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);

        // Overflow
        cycle(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
        cycle(1'b1, OP_DEC, 32'h8000_0000, 32'd0, 1'b1);
        chk("ovf_add_r", {32'd0, result}, 64'h8000_0000);
        chk("ovf_add_f", {60'd0, flags}, 64'h9);
        cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
        chk("ovf_dec_r", {32'd0, result}, 64'h7FFF_FFFF);
        chk("ovf_dec_f", {60'd0, flags}, 64'h1);
        cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);

        // Backpressure
        cycle(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0);
        cycle(1'b1, OP_ADD, 32'd2, 32'd2, 1'b0);
        chk("bp_ready_low", {63'd0, ready}, 64'd0);
        chk("bp_hold1", {32'd0, result}, 64'd2);
        cycle(1'b1, OP_ADD, 32'd9, 32'd9, 1'b0);
        chk("bp_hold2", {32'd0, result}, 64'd2);
        cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
        chk("bp_second", {32'd0, result}, 64'd4);
        chk("bp_second_ack", {63'd0, ack}, 64'd1);
        cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
        chk("bp_drained", {63'd0, ack}, 64'd0);

        // Logic ops at WIDTH=8 (32-bit instance idle and empty meanwhile)
        enable = 1'b0; ack_ready = 1'b1;
        run8("not8", OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'h8);
        run8("or8",  OP_OR,  8'hA0, 8'h05, 8'hA5, 4'h8);
        run8("and8", OP_AND, 8'hA0, 8'h05, 8'h00, 4'h4);

        // Idle
        for (int i = 0; i < 10; i++) cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);

        // Random stream with random backpressure
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick(),
                  ($urandom_range(0, 3) != 0));
        end

        // Reset mid-stream with both stages full
        cycle(1'b1, OP_ADD, 32'd1, 32'd0, 1'b0);
        cycle(1'b1, OP_ADD, 32'd2, 32'd0, 1'b0);
        cycle(1'b1, OP_ADD, 32'd3, 32'd0, 1'b0);
        enable = 1'b0;
        chk("full_ack", {63'd0, ack}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", {63'd0, ack}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);
        chk("midrst_flags", {60'd0, flags}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_ready", {63'd0, ready}, 64'd1);
        chk("postrst_ack", {63'd0, ack}, 64'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
        cycle(1'b1, OP_SUB, 32'd10, 32'd4, 1'b1);
        cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
        chk("postrst_sub", {32'd0, result}, 64'd6);
        cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the team's combinational 32-bit ALU. Adds a clock, a valid/ready request handshake, a result handshake with downstream backpressure, and registered status flags. The opcode map and arithmetic are unchanged, so software-visible behaviour is identical. Sits between the issue logic and the writeback/result bus in the datapath.

## Interface
- WIDTH, 32, operand/result width in bits; must be at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  request valid.
- A  in  WIDTH  operand A; sampled on accept.
- B  in  WIDTH  operand B; sampled on accept.
- opcode  in  3  operation, encoded as alu_op_e.
- ready  out  1  block can accept a request this cycle.
- result  out  WIDTH  result; valid while ack=1, otherwise 0.
- flags  out  4  {negative, zero, carry, overflow}; valid while ack=1, otherwise 0.
- ack  out  1  result valid.
- ack_ready  in  1  downstream consumes the result this cycle.

## Operation
- Accept: a request is accepted on a rising edge when enable=1 and ready=1. A, B and opcode are captured into stage 1 (S1).
- Stage 2 (S2): holds the computed result and flags. ack equals S2 valid.
- Retire: the S2 entry retires on a rising edge when ack=1 and ack_ready=1.
- Pipeline advance rules:
  - S2 loads when S1 is valid and (S2 is empty or S2 retires).
  - S1 loads when accepted. S1 otherwise clears when it advances to S2.
  - ready = !S1_valid || S2_load_possible, where S2_load_possible = !S2_valid || ack_ready. ready is combinational from ack_ready.
- Opcodes:
  - 000: A+B
  - 001: A−B
  - 010: A+1
  - 011: A−1
  - 100: A
  - 101: ~A
  - 110: A|B
  - 111: A&B
- Arithmetic is computed at WIDTH+1 bits and the result is truncated to WIDTH. There is no saturation.
- Flag rules:
  - carry: carry-out for add and increment. For subtract and decrement, carry is the borrow (1 when the minuend is unsigned-less than the subtrahend). carry=0 for pass, NOT, OR and AND.
  - overflow: signed two's-complement overflow for add, sub, inc and dec. overflow=0 otherwise.
  - zero: result == 0.
  - negative: result[WIDTH−1].
- Outputs never float. result and flags are 0 whenever ack=0.

## Timing
- Reset (rst_n=0, asynchronous): S1_valid=0, S2_valid=0, ack=0, result=0, flags=0. After reset, ready reads 1.
- Latency: accept at edge N gives ack=1 after edge N+1, provided there is no stall.
- Throughput: one request per cycle while ack_ready=1.
- Stall: with ack=1 and ack_ready=0, the S2 contents hold stable. S1 may still accept one request; after that, ready=0.
- Simultaneous retire and load in the same edge: S2 takes the new entry and ack stays 1. No bubble is inserted.
- Deassertion of rst_n is synchronised externally. The block does no internal synchroniser.
- Reset mid-operation discards both stages. Requests in flight are not acknowledged.
- enable and opcode are don't-care while ready=0. Held values are not re-sampled until accept.

## Structure
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e: OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_PASS, OP_NOT, OP_OR, OP_AND.
  - packed struct alu_flags_t {n, z, c, v}.
- Sub-module alu_core, combinational, parameter WIDTH. It maps (A, B, opcode) to (result, flags) and is instantiated between S1 and S2.
- alu_pipe contains only the stage registers and the handshake logic. Target size is roughly 150–250 lines of RTL in total.

## Test plan
- Reset: assert rst_n=0 mid-stream with both stages full. Required: ack=0, result=0, flags=0 immediately; ready=1 after release.
- Back-to-back stream with ack_ready=1: ADD 5+7, SUB 3−5, INC 0xFFFFFFFF in consecutive cycles. Required: ack on three consecutive cycles with results and flags:
  - 12, flags 0000.
  - 0xFFFFFFFE, negative=1, carry(borrow)=1.
  - 0, zero=1, carry=1.
- Overflow: ADD 0x7FFFFFFF+1 → 0x80000000, negative=1, overflow=1, carry=0. DEC 0x80000000 → 0x7FFFFFFF, overflow=1.
- Backpressure: hold ack_ready=0 and issue two requests. Required: ready drops to 0 after the second accept; S2 result is held stable. Release ack_ready: both results retire in order on consecutive cycles with no loss and no duplicate.
- Logic ops at WIDTH=8: NOT 0x0F → 0xF0; OR 0xA0|0x05 → 0xA5; AND 0xA0&0x05 → 0x00 with zero=1. Carry and overflow are 0 for all three.
- Idle: enable=0 for 10 cycles. Required: ack stays 0 and result stays 0.
